// File: rtl/counter_tick_gen.sv
// counter_tick_gen: turns raw run/stop and single-step push-buttons into a
// clean one-cycle count-enable pulse (Tick) for the 4-bit up counter.
// Buttons are synchronised, debounced and edge-detected; a two-state
// run/stop machine either lets a prescaler pace Tick or passes step presses.
module counter_tick_gen #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_50M,
  input  logic Reset,
  input  logic Btn_run,
  input  logic Btn_step,
  output logic Tick,
  output logic Running
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // Bit 0 carries the run/stop button, bit 1 the step button.
  localparam int RUN_IDX  = 0;
  localparam int STEP_IDX = 1;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];
  logic [CW-1:0] cnt;
  state_t        state;
  logic          press_run;
  logic          press_step;

  assign raw        = {Btn_step, Btn_run};
  assign press_run  = press[RUN_IDX];
  assign press_step = press[STEP_IDX];

  // Two-flop synchroniser bringing both asynchronous buttons into clk_50M.
  always_ff @(posedge clk_50M) begin
    if (!Reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debouncer: accept a new level only after DEB_CYCLES consecutive mismatches.
  always_ff @(posedge clk_50M) begin
    if (!Reset) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= s2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect: one-cycle press pulse per accepted press.
  always_ff @(posedge clk_50M) begin
    if (!Reset) begin
      deb_d <= '0;
      press <= '0;
    end else begin
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  // Run/stop machine with prescaler; run press outranks both step and terminal count.
  always_ff @(posedge clk_50M) begin
    if (!Reset) begin
      state   <= STOP;
      cnt     <= '0;
      Tick    <= 1'b0;
      Running <= 1'b0;
    end else begin
      Tick <= 1'b0;
      case (state)
        STOP: begin
          cnt <= '0;
          if (press_run) begin
            state   <= RUN;
            Running <= 1'b1;
          end else if (press_step) begin
            Tick <= 1'b1;
          end
        end
        RUN: begin
          if (press_run) begin
            state   <= STOP;
            Running <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            Tick <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= STOP;
          Running <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_tick_gen.sv
// Self-checking bench for counter_tick_gen with DIV=5, DEB_CYCLES=4.
// Each table record gives per-cycle button/reset masks and the expected
// Tick/Running after every edge; expectations go through a scoreboard queue.
module tb_counter_tick_gen;

  localparam int DIV  = 5;
  localparam int DEB  = 4;
  localparam int NCYC = 40;
  localparam int NVEC = 9;

  logic clk_50M  = 1'b0;
  logic Reset    = 1'b0;
  logic Btn_run  = 1'b0;
  logic Btn_step = 1'b0;
  logic Tick;
  logic Running;

  typedef struct {
    string           name;
    logic [NCYC-1:0] rst_lo;
    logic [NCYC-1:0] run;
    logic [NCYC-1:0] step;
    logic [NCYC-1:0] exp_running;
    logic [NCYC-1:0] exp_tick;
  } vec_t;

  typedef struct {
    string name;
    int    cyc;
    logic  tick;
    logic  running;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   fails  = 0;

  counter_tick_gen #(
    .DIV       (DIV),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk_50M (clk_50M),
    .Reset   (Reset),
    .Btn_run (Btn_run),
    .Btn_step(Btn_step),
    .Tick    (Tick),
    .Running (Running)
  );

  // 50 MHz clock.
  always #10 clk_50M = ~clk_50M;

  function automatic logic [NCYC-1:0] span(input int lo, input int hi);
    logic [NCYC-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NCYC-1:0] bit_at(input int n);
    logic [NCYC-1:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic applyStimulus(input logic rst_level, input logic b_run, input logic b_step,
                               input logic e_tick, input logic e_running,
                               input string name, input int cyc);
    exp_t e;
    Reset    = rst_level;
    Btn_run  = b_run;
    Btn_step = b_step;
    e.name    = name;
    e.cyc     = cyc;
    e.tick    = e_tick;
    e.running = e_running;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it to the outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (Tick !== e.tick) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d Tick: got %b required %b", e.name, e.cyc, Tick, e.tick);
    end
    checks++;
    if (Running !== e.running) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d Running: got %b required %b", e.name, e.cyc, Running, e.running);
    end
  endtask

  task automatic applyReset();
    @(negedge clk_50M);
    Reset    = 1'b0;
    Btn_run  = 1'b0;
    Btn_step = 1'b0;
    repeat (2) @(posedge clk_50M);
  endtask

  initial begin
    // Edge numbers below count from cycle 0, the first edge after reset release.
    vecs[0] = '{"run_start", '0, span(0, 39), '0, span(7, 39),
                bit_at(12) | bit_at(17) | bit_at(22) | bit_at(27) | bit_at(32) | bit_at(37)};
    vecs[1] = '{"bounce", '0, span(0, 2) | span(5, 7), '0, '0, '0};
    vecs[2] = '{"step_stop", '0, '0, span(0, 9), '0, bit_at(7)};
    vecs[3] = '{"step_hold", '0, '0, span(0, 39), '0, bit_at(7)};
    vecs[4] = '{"step_in_run", '0, span(0, 39), span(15, 25), span(7, 39),
                bit_at(12) | bit_at(17) | bit_at(22) | bit_at(27) | bit_at(32) | bit_at(37)};
    vecs[5] = '{"stop_on_tc", '0, span(0, 8) | span(15, 39), span(15, 39), span(7, 21),
                bit_at(12) | bit_at(17)};
    vecs[6] = '{"stop_restart", '0, span(0, 8) | span(16, 19) | span(26, 39), '0,
                span(7, 22) | span(33, 39),
                bit_at(12) | bit_at(17) | bit_at(22) | bit_at(38)};
    vecs[7] = '{"reset_in_run", bit_at(11), span(0, 39), '0, span(7, 10) | span(19, 39),
                bit_at(24) | bit_at(29) | bit_at(34) | bit_at(39)};
    vecs[8] = '{"step_glitch", '0, '0, span(0, 2) | span(4, 6) | span(8, 10), '0, '0};

    // Hand sequence: reset held 3 edges while both buttons toggle, then release.
    applyReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50M);
      applyStimulus(1'b0, i[0], ~i[0], 1'b0, 1'b0, "reset_hold", i);
      @(posedge clk_50M);
      #1;
      checkOutput();
    end
    for (int i = 3; i < 12; i++) begin
      @(negedge clk_50M);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_release", i);
      @(posedge clk_50M);
      #1;
      checkOutput();
    end

    // Table-driven scenarios, each from a fresh reset.
    for (int v = 0; v < NVEC; v++) begin
      applyReset();
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk_50M);
        applyStimulus(~vecs[v].rst_lo[c], vecs[v].run[c], vecs[v].step[c],
                      vecs[v].exp_tick[c], vecs[v].exp_running[c], vecs[v].name, c);
        @(posedge clk_50M);
        #1;
        checkOutput();
      end
    end

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
